// File: rtl/seq_fixdiv_if.sv
// Handshake bundle for seq_fixdiv: operand request channel and result channel.
// master = operand producer / result consumer, slave = the divider.
interface seq_fixdiv_if #(
   parameter int W    = 24,
   parameter int FRAC = 0
);
   localparam int QW = W + FRAC;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] quotient;
   logic [W-1:0]  remainder;
   logic          dbz;
   logic          busy;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, dbz, busy
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, dbz, busy
   );
endinterface

// File: rtl/seq_fixdiv.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first, with FRAC fractional bits.
// Define SEQ_FIXDIV_DBZ_EN to short-circuit divide-by-zero to DONE and flag it on dbz.
module seq_fixdiv #(
   parameter int W    = 24,
   parameter int FRAC = 0
) (
   input  logic         clk,
   input  logic         rst,
   seq_fixdiv_if.slave  bus
);
   localparam int QW = W + FRAC;
   localparam int CW = $clog2(QW + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [W:0]    rem_q;
   logic [QW-1:0] num_q;
   logic [W-1:0]  dvs_q;
   logic [QW-1:0] quot_q;
   logic [W-1:0]  remo_q;
   logic          in_ready_q;
   logic          busy_q;
   logic          out_valid_q;

   logic [QW-1:0] dvd_sh;
   logic [W:0]    rem_sh;
   logic [W:0]    rem_d;
   logic [QW-1:0] num_d;
   logic          take;

   // num_q shifts dividend bits out of the top while quotient bits enter at the bottom.
   always_comb begin
      dvd_sh = QW'(bus.dividend) << FRAC;
      rem_sh = (rem_q << 1) | {{W{1'b0}}, num_q[QW-1]};
      take   = (rem_sh >= {1'b0, dvs_q});
      rem_d  = take ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
      num_d  = {num_q[QW-2:0], take};
   end

`ifdef SEQ_FIXDIV_DBZ_EN
   logic dbz_q;
   logic dvs_zero;
   assign dvs_zero = (bus.divisor == '0);
   assign bus.dbz  = dbz_q;
`else
   assign bus.dbz  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         num_q       <= '0;
         dvs_q       <= '0;
         quot_q      <= '0;
         remo_q      <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef SEQ_FIXDIV_DBZ_EN
         dbz_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  dvs_q      <= bus.divisor;
                  num_q      <= dvd_sh;
                  rem_q      <= '0;
                  in_ready_q <= 1'b0;
`ifdef SEQ_FIXDIV_DBZ_EN
                  if (dvs_zero) begin
                     state_q     <= S_DONE;
                     cnt_q       <= '0;
                     out_valid_q <= 1'b1;
                     quot_q      <= '1;
                     remo_q      <= dvd_sh[W-1:0];
                     dbz_q       <= 1'b1;
                  end else begin
                     state_q <= S_BUSY;
                     cnt_q   <= CW'(QW);
                     busy_q  <= 1'b1;
                  end
`else
                  state_q <= S_BUSY;
                  cnt_q   <= CW'(QW);
                  busy_q  <= 1'b1;
`endif
               end
            end
            S_BUSY: begin
               num_q <= num_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  quot_q      <= num_d;
                  remo_q      <= rem_d[W-1:0];
`ifdef SEQ_FIXDIV_DBZ_EN
                  dbz_q       <= 1'b0;
`endif
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.quotient  = quot_q;
   assign bus.remainder = remo_q;
endmodule

// File: tb/tb_seq_fixdiv.sv
// Scoreboard bench for seq_fixdiv: a W=24/FRAC=0 instance and a W=8/FRAC=8 instance,
// random and directed operands checked against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_fixdiv;
   localparam int W  = 24;
   localparam int FR = 0;
   localparam int QW = W + FR;
   localparam int W2 = 8;
   localparam int F2 = 8;

`ifdef SEQ_FIXDIV_DBZ_EN
   localparam bit DBZ_EN = 1'b1;
`else
   localparam bit DBZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_fixdiv_if #(.W(W),  .FRAC(FR)) bus  ();
   seq_fixdiv_if #(.W(W2), .FRAC(F2)) bus2 ();

   seq_fixdiv #(.W(W),  .FRAC(FR)) dut  (.clk(clk), .rst(rst), .bus(bus));
   seq_fixdiv #(.W(W2), .FRAC(F2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   typedef struct {
      longint q;
      longint r;
      bit     dbz;
      int     cap;
      int     lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp2_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   stall_n = 0;
   bit   rand_ready = 1'b0;
   int   last_rise = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input int w, input int frac, input longint dvd,
                                  input longint dvs, input int cap);
      exp_t   e;
      longint sh;
      sh = dvd << frac;
      if (dvs == 0) begin
         e.q   = (longint'(1) << (w + frac)) - 1;
         e.r   = sh & ((longint'(1) << w) - 1);
         e.dbz = DBZ_EN;
         e.lat = DBZ_EN ? 1 : (w + frac);
      end else begin
         e.q   = sh / dvs;
         e.r   = sh % dvs;
         e.dbz = 1'b0;
         e.lat = w + frac;
      end
      e.cap = cap;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the capture edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep, output int cap);
      int budget = 300;
      cap = -1;
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      while (budget > 0 && bus.in_ready !== 1'b1) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         check("capture_timeout", 64'd0, 64'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      cap = cyc;
      exp_q.push_back(model(W, FR, longint'(a), longint'(b), cap));
      bus.in_valid = keep;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
   endtask

   task automatic issue2(input logic [W2-1:0] a, input logic [W2-1:0] b);
      int budget = 300;
      bus2.in_valid = 1'b1;
      bus2.dividend = a;
      bus2.divisor  = b;
      while (budget > 0 && bus2.in_ready !== 1'b1) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         check("capture2_timeout", 64'd0, 64'd1);
         bus2.in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      exp2_q.push_back(model(W2, F2, longint'(a), longint'(b), cyc));
      bus2.in_valid = 1'b0;
      bus2.dividend = W2'($urandom);
      bus2.divisor  = W2'($urandom);
   endtask

   task automatic drain();
      int budget = 400;
      while (budget > 0 && (exp_q.size() != 0 || exp2_q.size() != 0 ||
                            bus.out_valid === 1'b1 || bus2.out_valid === 1'b1)) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check("drain_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   // Main-instance monitor; also owns out_ready so the decision and the check share one sample.
   exp_t cur;
   bit   have = 1'b0;
   bit   prev_v = 1'b0;
   bit   prev_hs = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         have = 1'b0;
         prev_v = 1'b0;
         prev_hs = 1'b0;
         bus.out_ready = 1'b0;
      end else begin
         if (prev_hs) begin
            check("in_ready_after_take", 64'(bus.in_ready), 64'd1);
            check("out_valid_after_take", 64'(bus.out_valid), 64'd0);
         end
         if (bus.out_valid === 1'b1 && !prev_v) begin
            last_rise = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 64'd1, 64'd0);
               have = 1'b0;
            end else begin
               cur  = exp_q.pop_front();
               have = 1'b1;
               check("latency", longint'(cyc - cur.cap), longint'(cur.lat));
            end
         end
         if (bus.out_valid === 1'b1 && have) begin
            check("quotient", 64'(bus.quotient), cur.q);
            check("remainder", 64'(bus.remainder), cur.r);
            check("dbz", 64'(bus.dbz), 64'(cur.dbz));
            check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
            check("busy_in_done", 64'(bus.busy), 64'd0);
         end
         if (bus.out_valid === 1'b1 && stall_n > 0) begin
            bus.out_ready = 1'b0;
            stall_n--;
         end else begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         prev_hs = (bus.out_valid === 1'b1) && bus.out_ready;
         prev_v  = (bus.out_valid === 1'b1) && !bus.out_ready;
      end
   end

   bit prev2_v = 1'b0;
   always @(negedge clk) begin
      exp_t e2;
      bus2.out_ready = 1'b1;
      if (rst) begin
         prev2_v = 1'b0;
      end else begin
         if (bus2.out_valid === 1'b1 && !prev2_v) begin
            if (exp2_q.size() == 0) begin
               check("unexpected_out_valid2", 64'd1, 64'd0);
            end else begin
               e2 = exp2_q.pop_front();
               check("latency2", longint'(cyc - e2.cap), longint'(e2.lat));
               check("quotient2", 64'(bus2.quotient), e2.q);
               check("remainder2", 64'(bus2.remainder), e2.r);
            end
         end
         prev2_v = 1'b0;
      end
   end

   initial begin
      int cap1;
      int cap2;
      logic [W-1:0] a;
      logic [W-1:0] b;
      bus.in_valid  = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus2.in_valid = 1'b0;
      bus2.dividend = '0;
      bus2.divisor  = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_dbz", 64'(bus.dbz), 64'd0);
      check("rst_quotient", 64'(bus.quotient), 64'd0);
      check("rst_remainder", 64'(bus.remainder), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(24'd100, 24'd7, 1'b0, cap1);
      drain();
      stall_n = 10;
      issue(24'hFFFFFF, 24'd1, 1'b0, cap1);
      drain();
      issue(24'd5, 24'd0, 1'b0, cap1);
      drain();

      issue(24'd20, 24'd6, 1'b1, cap1);
      issue(24'd6, 24'd20, 1'b0, cap2);
      check("b2b_gap", longint'(cap2 - last_rise), 64'd2);
      drain();

      issue2(8'd1, 8'd3);
      issue2(8'd200, 8'd0);
      issue2(8'd255, 8'd255);
      drain();
      for (int i = 0; i < 12; i++) begin
         issue2(W2'($urandom), W2'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 255)));
      end
      drain();

      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2:    b = W'($urandom_range(1, 15));
            3:       b = a;
            default: b = W'($urandom);
         endcase
         issue(a, b, 1'b0, cap1);
      end
      drain();
      rand_ready = 1'b0;

      issue(24'hABCDEF, 24'd17, 1'b0, cap1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      exp2_q.delete();
      #1;
      check("abort_out_valid", 64'(bus.out_valid), 64'd0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_in_ready", 64'(bus.in_ready), 64'd1);
      check("abort_quotient", 64'(bus.quotient), 64'd0);
      check("abort_remainder", 64'(bus.remainder), 64'd0);
      check("abort_dbz", 64'(bus.dbz), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      issue(24'd9, 24'd3, 1'b0, cap1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/seq_fixdiv.md
SEQ_FIXDIV -- requirements
Module: seq_fixdiv

Interface
REQ-001 The block SHALL have parameter W, default 24, giving the dividend, divisor and remainder width in bits (W >= 2).
REQ-002 The block SHALL have parameter FRAC, default 0, giving the number of fractional quotient bits (FRAC >= 0).
REQ-003 The block SHALL derive QW = W + FRAC as the quotient width; QW is not overridable.
REQ-004 The block SHALL run on one clock and use an asynchronous, active-high reset.
REQ-005 The block SHALL have the following ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dividend  input  W  unsigned dividend.
- divisor  input  W  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- quotient  output  QW  unsigned quotient.
- remainder  output  W  unsigned remainder.
- dbz  output  1  divide-by-zero flag for the current result.
- busy  output  1  high while iterating.

Function
REQ-006 The block SHALL compute quotient = floor((dividend << FRAC) / divisor) and remainder = (dividend << FRAC) mod divisor, both unsigned; for divisor >= 1 the quotient cannot overflow QW bits.
REQ-007 The block SHALL use a restoring, one-quotient-bit-per-cycle algorithm, MSB first, with an internal partial remainder at least W+1 bits wide.
REQ-008 The block SHALL implement the states IDLE, BUSY and DONE.
REQ-009 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in BUSY; out_valid SHALL be 1 only in DONE.
REQ-010 A transfer SHALL occur on an edge where in_valid and in_ready are both 1; the block SHALL capture both operands on that edge, enter BUSY and load the iteration counter with QW.
REQ-011 The block SHALL ignore operand changes after capture until the next transfer.
REQ-012 In BUSY, each edge SHALL resolve one quotient bit and decrement the counter; the edge that resolves the last bit SHALL enter DONE.
REQ-013 For divisor /= 0, out_valid SHALL rise exactly QW edges after the capture edge.
REQ-014 In DONE, quotient, remainder and dbz SHALL be held stable until out_ready = 1; on that edge the block SHALL return to IDLE.
REQ-015 A new transfer SHALL not be possible on the same edge as the DONE -> IDLE transition; the earliest next capture is the following edge.
REQ-016 Sustained throughput SHALL therefore be one division per QW+2 cycles.
REQ-017 For divisor = 0, the outputs SHALL be quotient = all ones and remainder = low W bits of (dividend << FRAC).
REQ-018 quotient and remainder SHALL hold their previous values outside DONE, and SHALL not be required to be meaningful there.

Reset
REQ-019 While rst = 1, the block SHALL hold state IDLE with in_ready = 1, out_valid = 0, busy = 0, dbz = 0, quotient = 0, remainder = 0 and counter = 0, regardless of the clock.
REQ-020 Reset asserted in BUSY or DONE SHALL abort the operation with no out_valid pulse; the first capture is possible on the first edge after rst deasserts.

Configuration
REQ-021 Macro SEQ_FIXDIV_DBZ_EN defined: a capture with divisor = 0 SHALL go directly to DONE on the capture edge's successor state, so out_valid rises 1 edge after capture, with the REQ-017 values and dbz = 1.
REQ-022 SEQ_FIXDIV_DBZ_EN defined: dbz SHALL be 0 for all nonzero-divisor results.
REQ-023 Macro SEQ_FIXDIV_DBZ_EN undefined: divisor = 0 SHALL take the normal QW-edge latency and produce the REQ-017 values; dbz SHALL be a constant 0.

Verification
REQ-024 W=24, FRAC=0, dividend=100, divisor=7 -> out_valid exactly 24 edges after capture, quotient=14, remainder=2, dbz=0.
REQ-025 W=8, FRAC=8, dividend=1, divisor=3 -> out_valid 16 edges after capture, quotient=85, remainder=1.
REQ-026 W=24, dividend=0xFFFFFF, divisor=1 with out_ready held 0 for 10 cycles after out_valid -> quotient=0xFFFFFF, remainder=0 held stable the whole time, in_ready=0 throughout; in_ready=1 one cycle after the out_ready edge.
REQ-027 W=24, dividend=5, divisor=0 -> with SEQ_FIXDIV_DBZ_EN: out_valid 1 edge after capture, dbz=1, quotient=0xFFFFFF, remainder=5; without it: same values after 24 edges, dbz=0.
REQ-028 rst pulsed 10 cycles into a W=24 division -> no out_valid pulse; all outputs at reset values; a following 9/3 capture yields quotient=3, remainder=0.
REQ-029 Back-to-back operations 20/6 then 6/20 with out_ready=1 and in_valid=1 -> results (3,2) then (0,6); second capture exactly 2 edges after the first out_valid rise.
